// File: rtl/contador_pkg.sv
// Shared types and constants for the 4-bit counter sequencing controller.
//   state_t    : controller state (IDLE / RUN / PAUSE)
//   MODE_*     : one-hot mode words driven on sel_out towards the encoder
//   CNT_W      : width of the counter value and of the mode word
//   next_mode  : mode rotation UP -> DOWN -> PINGPONG -> HOLD -> UP
package contador_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MODE_UP   = 4'b0001;
    localparam logic [CNT_W-1:0] MODE_DOWN = 4'b0010;
    localparam logic [CNT_W-1:0] MODE_PING = 4'b0100;
    localparam logic [CNT_W-1:0] MODE_HOLD = 4'b1000;

    // A corrupted (non one-hot) mode word recovers to UP.
    function automatic logic [CNT_W-1:0] next_mode(input logic [CNT_W-1:0] mode);
        logic [CNT_W-1:0] nxt;
        unique case (mode)
            MODE_UP:   nxt = MODE_DOWN;
            MODE_DOWN: nxt = MODE_PING;
            MODE_PING: nxt = MODE_HOLD;
            MODE_HOLD: nxt = MODE_UP;
            default:   nxt = MODE_UP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/controlador_contador4bits_if.sv
// Board-side bundle of the counter controller.
//   btn_start/btn_pause/btn_clear/btn_mode : raw push buttons, asynchronous to clk
//   load_req/load_val                      : synchronous one-cycle load strobe and value
//   sel_out                                : one-hot mode word for the encoder stage
//   count/running/wrap                     : registered counter status
// master drives the buttons and load strobe; slave is the controller.
interface controlador_contador4bits_if;
    import contador_pkg::*;

    logic             btn_start;
    logic             btn_pause;
    logic             btn_clear;
    logic             btn_mode;
    logic             load_req;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] sel_out;
    logic [CNT_W-1:0] count;
    logic             running;
    logic             wrap;

    modport master (
        output btn_start,
        output btn_pause,
        output btn_clear,
        output btn_mode,
        output load_req,
        output load_val,
        input  sel_out,
        input  count,
        input  running,
        input  wrap
    );

    modport slave (
        input  btn_start,
        input  btn_pause,
        input  btn_clear,
        input  btn_mode,
        input  load_req,
        input  load_val,
        output sel_out,
        output count,
        output running,
        output wrap
    );

endinterface

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears every flop
//   raw   : asynchronous button level
//   pulse : one-cycle event on each low-to-high transition of the synchronized level
module sincroniza_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            prev_q <= sync_q[1];
        end
    end

    // A button held for any length of time yields a single pulse.
    assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/controlador_contador4bits.sv
// Sequencing controller for the 4-bit counter datapath.
//   DIV   : clock cycles per count step (>= 2)
//   LIMIT : maximum count value (1..15)
//   clk   : system clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of controlador_contador4bits_if (buttons, load strobe,
//           sel_out mode word, count, running, wrap)
// Buttons are synchronized and edge-detected, then a RUN/PAUSE/IDLE machine with
// a prescaler steps the counter according to the selected mode. All outputs are
// registered.
module controlador_contador4bits
    import contador_pkg::*;
#(
    parameter int unsigned DIV   = 50_000_000,
    parameter int unsigned LIMIT = 9
) (
    input logic                        clk,
    input logic                        rst_n,
    controlador_contador4bits_if.slave bus
);

    localparam int unsigned      PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [CNT_W-1:0] LIM       = CNT_W'(LIMIT);

    // Button events
    logic ev_start;
    logic ev_pause;
    logic ev_clear;
    logic ev_mode;

    sincroniza_borda u_sync_start (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_start),
        .pulse (ev_start)
    );

    sincroniza_borda u_sync_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_pause),
        .pulse (ev_pause)
    );

    sincroniza_borda u_sync_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_clear),
        .pulse (ev_clear)
    );

    sincroniza_borda u_sync_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.btn_mode),
        .pulse (ev_mode)
    );

    // State
    state_t           state_q;
    logic [CNT_W-1:0] mode_q;
    logic [CNT_W-1:0] count_q;
    logic [PW-1:0]    presc_q;
    logic             dir_down_q;
    logic             running_q;
    logic             wrap_q;

    // Next-step values, used only in a cycle where a step fires
    logic             step;
    logic [CNT_W-1:0] step_count;
    logic             step_wrap;
    logic             step_dir_down;
    logic [CNT_W-1:0] mode_next;
    logic [CNT_W-1:0] load_clamped;

    assign step         = (state_q == RUN) && (presc_q == PRESC_MAX);
    assign mode_next    = next_mode(mode_q);
    assign load_clamped = (bus.load_val > LIM) ? LIM : bus.load_val;

    always_comb begin
        step_count    = count_q;
        step_wrap     = 1'b0;
        step_dir_down = dir_down_q;
        unique case (mode_q)
            MODE_UP: begin
                if (count_q >= LIM) begin
                    step_count = '0;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = count_q + CNT_W'(1);
                end
            end
            MODE_DOWN: begin
                if (count_q == '0) begin
                    step_count = LIM;
                    step_wrap  = 1'b1;
                end else begin
                    step_count = count_q - CNT_W'(1);
                end
            end
            MODE_PING: begin
                // Reversal lands one away from the end point so the end value
                // is shown only once per sweep.
                if (!dir_down_q) begin
                    if (count_q >= LIM) begin
                        step_dir_down = 1'b1;
                        step_count    = LIM - CNT_W'(1);
                        step_wrap     = 1'b1;
                    end else begin
                        step_count = count_q + CNT_W'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        step_dir_down = 1'b0;
                        step_count    = CNT_W'(1);
                        step_wrap     = 1'b1;
                    end else begin
                        step_count = count_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                // HOLD: value frozen, prescaler keeps running.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_UP;
            count_q    <= '0;
            presc_q    <= '0;
            dir_down_q <= 1'b0;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;

            // Prescaler advances only in RUN and is frozen (not cleared) by PAUSE.
            if (state_q == RUN) begin
                presc_q <= step ? '0 : presc_q + PW'(1);
                if (step) begin
                    count_q    <= step_count;
                    wrap_q     <= step_wrap;
                    dir_down_q <= step_dir_down;
                end
            end

            // Only the highest-priority event acts, even when it has no effect
            // in the current state (e.g. pause in IDLE still masks start).
            if (ev_clear) begin
                state_q    <= IDLE;
                running_q  <= 1'b0;
                count_q    <= '0;
                presc_q    <= '0;
                dir_down_q <= 1'b0;
                wrap_q     <= 1'b0;
            end else if (ev_pause) begin
                if (state_q == RUN) begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
            end else if (ev_start) begin
                if (state_q != RUN) begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
            end else if (ev_mode) begin
                if (state_q != RUN) begin
                    mode_q <= mode_next;
                    if (mode_next == MODE_PING) begin
                        dir_down_q <= 1'b0;
                    end
                end
            end else if (bus.load_req) begin
                if (state_q != RUN) begin
                    count_q <= load_clamped;
                end
            end
        end
    end

    assign bus.sel_out = mode_q;
    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_controlador_contador4bits.sv
// Self-checking bench for controlador_contador4bits (DIV=4, LIMIT=9): directed
// scenarios followed by randomized button/load traffic, every cycle compared
// against a behavioural model of the controller.
module tb_controlador_contador4bits;

    localparam int unsigned DIV   = 4;
    localparam int unsigned LIMIT = 9;
    localparam int          DIVI  = 4;
    localparam int          LIM   = 9;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pin;      // [0] start [1] pause [2] clear [3] mode
    logic       ld_req;
    logic [3:0] ld_val;

    always #5 clk = ~clk;

    controlador_contador4bits_if bus_if ();

    assign bus_if.btn_start = pin[0];
    assign bus_if.btn_pause = pin[1];
    assign bus_if.btn_clear = pin[2];
    assign bus_if.btn_mode  = pin[3];
    assign bus_if.load_req  = ld_req;
    assign bus_if.load_val  = ld_val;

    controlador_contador4bits #(
        .DIV   (DIV),
        .LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: mode index 0 UP, 1 DOWN, 2 PINGPONG, 3 HOLD; dir +1/-1
    int m_st, m_mode, m_cnt, m_presc, m_dir, m_wrap;
    bit h1 [4];
    bit h2 [4];
    bit h3 [4];

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st    = S_IDLE;
        m_mode  = 0;
        m_cnt   = 0;
        m_presc = 0;
        m_dir   = 1;
        m_wrap  = 0;
        for (int b = 0; b < 4; b++) begin
            h1[b] = 1'b0;
            h2[b] = 1'b0;
            h3[b] = 1'b0;
        end
    endtask

    // One rising edge of behaviour: a pin level seen at edge k becomes an
    // event at edge k+2 if it was low at edge k+1-2.
    task automatic model_edge();
        int ev [4];
        bit step;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 4; b++) begin
            ev[b] = int'(h2[b] && !h3[b]);
            h3[b] = h2[b];
            h2[b] = h1[b];
            h1[b] = pin[b];
        end
        m_wrap = 0;
        step   = (m_st == S_RUN) && (m_presc == DIVI - 1);
        if (m_st == S_RUN) m_presc = (m_presc + 1) % DIVI;
        if (step) begin
            case (m_mode)
                0: begin
                    if (m_cnt == LIM) m_wrap = 1;
                    m_cnt = (m_cnt + 1) % (LIM + 1);
                end
                1: begin
                    if (m_cnt == 0) m_wrap = 1;
                    m_cnt = (m_cnt + LIM) % (LIM + 1);
                end
                2: begin
                    if (m_dir > 0 && m_cnt == LIM) begin
                        m_dir = -1; m_cnt = LIM - 1; m_wrap = 1;
                    end else if (m_dir < 0 && m_cnt == 0) begin
                        m_dir = 1; m_cnt = 1; m_wrap = 1;
                    end else begin
                        m_cnt = m_cnt + m_dir;
                    end
                end
                default: ;
            endcase
        end
        if (ev[2] != 0) begin
            m_st = S_IDLE; m_cnt = 0; m_presc = 0; m_dir = 1; m_wrap = 0;
        end else if (ev[1] != 0) begin
            if (m_st == S_RUN) m_st = S_PAUSE;
        end else if (ev[0] != 0) begin
            m_st = S_RUN;
        end else if (ev[3] != 0) begin
            if (m_st != S_RUN) begin
                m_mode = (m_mode + 1) % 4;
                if (m_mode == 2) m_dir = 1;
            end
        end else if (ld_req) begin
            if (m_st != S_RUN) m_cnt = (int'(ld_val) > LIM) ? LIM : int'(ld_val);
        end
    endtask

    task automatic compare();
        check_val("count", int'(bus_if.count), m_cnt);
        check_val("sel_out", int'(bus_if.sel_out), 1 << m_mode);
        check_val("running", int'(bus_if.running), int'(m_st == S_RUN));
        check_val("wrap", int'(bus_if.wrap), m_wrap);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input int b, input int hold);
        pin[b] = 1'b1;
        repeat (hold) cycle();
        pin[b] = 1'b0;
    endtask

    task automatic bound_ok(input string tag, input int n, input int budget);
        check_val(tag, int'(n < budget), 1);
    endtask

    initial begin
        int n;
        int wraps;
        pin    = 4'b0000;
        ld_req = 1'b0;
        ld_val = 4'd0;
        rst_n  = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // UP from 0 through the wrap
        press(0, 2);
        wraps = 0;
        for (int i = 0; i < 48; i++) begin
            cycle();
            wraps += int'(bus_if.wrap);
        end
        check_val("up_wraps", wraps, 1);
        check_val("up_count_end", int'(bus_if.count), 1);

        // Asynchronous reset in the middle of RUN at count 5
        press(2, 1);
        idle(3);
        press(0, 1);
        n = 0;
        while (m_cnt != 5 && n < 40) begin cycle(); n++; end
        bound_ok("reach_5", n, 40);
        rst_n = 1'b0;
        #1;
        check_val("rst_count", int'(bus_if.count), 0);
        check_val("rst_sel", int'(bus_if.sel_out), 1);
        check_val("rst_running", int'(bus_if.running), 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        idle(2);

        // PINGPONG sweep
        press(3, 1); idle(4);
        press(3, 1); idle(4);
        check_val("ping_sel", int'(bus_if.sel_out), 4);
        press(0, 1);
        wraps = 0;
        for (int i = 0; i < 80; i++) begin
            cycle();
            wraps += int'(bus_if.wrap);
        end
        check_val("ping_wraps", wraps, 2);
        check_val("ping_count_end", int'(bus_if.count), 1);

        // Pause at 3 with prescaler 2, switch to DOWN, resume
        press(2, 1); idle(3);
        press(3, 1); idle(4);
        press(3, 1); idle(4);
        check_val("back_to_up", int'(bus_if.sel_out), 1);
        press(0, 1);
        n = 0;
        while (!(m_cnt == 2 && m_presc == 3) && n < 40) begin cycle(); n++; end
        bound_ok("reach_pause_point", n, 40);
        press(1, 1);
        idle(6);
        check_val("pause_hold", int'(bus_if.count), 3);
        check_val("pause_running", int'(bus_if.running), 0);
        press(3, 1); idle(3);
        check_val("pause_mode_down", int'(bus_if.sel_out), 2);
        press(0, 1);
        n = 0;
        while (!bus_if.running && n < 10) begin cycle(); n++; end
        bound_ok("resume_running", n, 10);
        n = 0;
        while (bus_if.count == 4'd3 && n < 10) begin cycle(); n++; end
        check_val("resume_delay", n, 2);
        check_val("resume_value", int'(bus_if.count), 2);

        // Start and pause together in IDLE; clear coinciding with a step
        press(2, 1); idle(3);
        pin[0] = 1'b1;
        pin[1] = 1'b1;
        idle(1);
        pin = 4'b0000;
        idle(5);
        check_val("start_pause_idle", int'(bus_if.running), 0);
        press(0, 1);
        n = 0;
        while (!(m_st == S_RUN && m_presc == 1) && n < 20) begin cycle(); n++; end
        bound_ok("reach_clear_point", n, 20);
        press(2, 1);
        idle(3);
        check_val("clear_step_count", int'(bus_if.count), 0);

        // Load clamping, load ignored in RUN, long button hold
        ld_val = 4'd12;
        ld_req = 1'b1;
        cycle();
        ld_req = 1'b0;
        check_val("load_clamp", int'(bus_if.count), 9);
        press(0, 1);
        idle(4);
        ld_val = 4'd3;
        ld_req = 1'b1;
        cycle();
        ld_req = 1'b0;
        idle(2);
        press(2, 1); idle(3);
        press(3, 100);
        idle(4);
        check_val("hold_once", int'(bus_if.sel_out), 4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                int unsigned thr;
                thr = (b == 2) ? 200 : 25;
                if (pin[b]) begin
                    if ($urandom_range(0, 2) == 0) pin[b] = 1'b0;
                end else if ($urandom_range(0, thr - 1) == 0) begin
                    pin[b] = 1'b1;
                end
            end
            ld_req = ($urandom_range(0, 9) == 0);
            ld_val = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
